// File: rtl/mem_port_arbiter.sv
// Shares one single-port syncram between a read-only fetch port and a
// load/store data port; data wins ties, bounded by a fetch-starvation streak.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_wr,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_cs,
   output logic                  mem_oe,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   localparam int            SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

   logic [SW-1:0]        streak_q, streak_d;
   owner_e               rd_owner_q, rd_owner_d;
   logic [CNT_WIDTH-1:0] stall_q, stall_d;

   // Data wins unless it has already taken MAX_D_STREAK grants against a waiting fetch.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (d_req && !(i_req && streak_q == STREAK_MAX)) d_gnt = 1'b1;
         else if (i_req)                                  i_gnt = 1'b1;
      end
   end

   always_comb begin
      mem_cs   = i_gnt | d_gnt;
      mem_we   = d_gnt & d_wr;
      mem_oe   = mem_cs & ~mem_we;
      mem_addr = '0;
      mem_din  = '0;
      if (d_gnt) begin
         mem_addr = d_addr;
         mem_din  = d_wdata;
      end else if (i_gnt) begin
         mem_addr = i_addr;
      end
   end

   always_comb begin
      streak_d   = streak_q;
      rd_owner_d = OWN_NONE;
      stall_d    = stall_q;
      if (!i_req || i_gnt)                        streak_d = '0;
      else if (d_gnt && streak_q != STREAK_MAX)   streak_d = streak_q + SW'(1);
      if (i_gnt)               rd_owner_d = OWN_I;
      else if (d_gnt && !d_wr) rd_owner_d = OWN_D;
      if (i_req && !i_gnt)     stall_d = stall_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         streak_q   <= '0;
         rd_owner_q <= OWN_NONE;
         stall_q    <= '0;
      end else begin
         streak_q   <= streak_d;
         rd_owner_q <= rd_owner_d;
         stall_q    <= stall_d;
      end
   end

   // Gated by reset so a read issued just before reset never reports valid.
   assign i_rvalid  = (rd_owner_q == OWN_I) && !reset;
   assign d_rvalid  = (rd_owner_q == OWN_D) && !reset;
   assign i_rdata   = mem_dout;
   assign d_rdata   = mem_dout;
   assign stall_cnt = stall_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one synchronous single-port memory between an instruction-fetch port (read-only) and a data load/store port. The target is our syncram: registered read, one-cycle latency, write committed at the clock edge. It lets the multi-cycle CPU run from a unified memory image instead of the split sram/syncram pair. Data accesses have priority, and a streak counter prevents fetch starvation.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (>=1)
CNT_WIDTH, 32, width of the fetch-stall performance counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request; held with i_addr stable until i_gnt
i_addr  input  ADDR_WIDTH  fetch address
i_gnt  output  1  fetch accepted this cycle (combinational)
i_rvalid  output  1  fetch data valid (cycle after grant)
i_rdata  output  DATA_WIDTH  fetch data
d_req  input  1  data request; held with d_wr/d_addr/d_wdata stable until d_gnt
d_wr  input  1  1 = store, 0 = load
d_addr  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  store data
d_gnt  output  1  data access accepted this cycle (combinational)
d_rvalid  output  1  load data valid (cycle after load grant; never for stores)
d_rdata  output  DATA_WIDTH  load data
mem_cs  output  1  memory chip select
mem_oe  output  1  memory output enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_din  output  DATA_WIDTH  memory write data
mem_dout  input  DATA_WIDTH  memory read data (registered inside memory)
stall_cnt  output  CNT_WIDTH  cycles with i_req=1 and i_gnt=0

Behaviour:
- Reset (sync, active-high):
  - streak=0, rd_owner=NONE, stall_cnt=0, i_rvalid=d_rvalid=0.
  - While reset=1: i_gnt=d_gnt=0, mem_cs=mem_we=mem_oe=0.
  - Requests present during reset are ignored; a read issued in the cycle before reset asserts produces no rvalid.
- Arbitration, combinational, at most one grant per cycle:
  - Neither req: no grant; mem_cs=0, mem_we=0.
  - One req only: grant that port.
  - Both req and streak<MAX_D_STREAK: grant data.
  - Both req and streak==MAX_D_STREAK: grant fetch.
- Memory drive on a grant:
  - mem_cs=1.
  - mem_addr = granted port's address.
  - mem_we = d_wr if data granted, else 0.
  - mem_oe = ~mem_we.
  - mem_din = d_wdata (don't-care when not writing).
  - With no grant: mem_addr and mem_din hold 0.
- Streak counter (registered):
  - Increments on a data grant while i_req=1.
  - Clears to 0 on a fetch grant, or on any cycle with i_req=0.
  - Saturates at MAX_D_STREAK.
- Read tracking:
  - rd_owner register records I, D or NONE for the read issued this cycle.
  - A store grant or no grant sets NONE.
  - Next cycle: i_rvalid=(rd_owner==I), d_rvalid=(rd_owner==D).
  - i_rdata=d_rdata=mem_dout; the value is meaningful only while the matching rvalid is high.
- Back-to-back operation:
  - A grant is allowed every cycle, so throughput is 1 access/cycle.
  - A response and a new grant may coincide.
  - A store at cycle N followed by a load of the same address at N+1 returns the new data.
- Stall counter:
  - Increments on each cycle with reset=0, i_req=1 and i_gnt=0.
  - Wraps modulo 2^CNT_WIDTH.
- Ports with rvalid=1 must not be required to deassert req; a new request may be granted in the same cycle rvalid is high.

Test Plan:
1. Fetch-only stream, addresses 0x00, 0x04, 0x08 on consecutive cycles, memory preloaded with word k at address 4k:
   - Required: i_gnt=1 each cycle.
   - Required: i_rvalid=1 one cycle later with i_rdata=0, 1, 2.
   - Required: d_rvalid stays 0; stall_cnt stays 0.
2. Store 0xDEADBEEF to 0x40, then a load of 0x40 on the next cycle:
   - Required: store cycle shows mem_we=1, mem_oe=0, no rvalid.
   - Required: load returns d_rvalid=1 with d_rdata=0xDEADBEEF one cycle after its grant.
3. i_req and d_req held high continuously, MAX_D_STREAK=4:
   - Required grant pattern: D, D, D, D, I, repeating.
   - Required: stall_cnt=4 after the first I grant.
   - Required: each rvalid routed to its owning port.
4. Simultaneous fetch and store at the same address 0x10, old value 5, new value 9:
   - Required: the data port wins.
   - Required: the next-cycle fetch grant returns 9.
5. Assert reset for 1 cycle while a fetch is in flight (granted the previous cycle):
   - Required: i_rvalid=0 the following cycle.
   - Required: grants=0 during reset; stall_cnt=0 and streak=0 afterwards.
6. d_req alone for 10 cycles, then i_req added:
   - Required: the streak does not accumulate while i_req=0.
   - Required: after i_req rises, exactly 4 more D grants precede the first I grant.
